uart_tx_frame: RTL and testbench

- Parametrised UART serial transmitter and successor to the fixed 8-bit/11-bit-frame parallel-in serial-out unit.
- Buffers words in an internal FIFO behind a valid/ready handshake.
- Computes parity internally: none, even, odd or mark, selected per word.
- Emits frames with 5–9 data bits and 1 or 2 stop bits, back-to-back with no idle gap while words are queued; sits between the host register interface and the TX pin.

---
 rtl/uart_tx_frame.sv | 161 ++++++++++++++++
 tb/tb_uart_tx_frame.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_frame.sv
// FIFO-buffered UART transmitter: 5..9 data bits, selectable parity per word, 1 or 2 stop bits.
// Frames are sent back-to-back with no idle bit while words are waiting in the FIFO.
module uart_tx_frame #(
    parameter int DATA_BITS  = 8,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 4,
    localparam int AW        = $clog2(FIFO_DEPTH)
) (
    input  logic                 baud_clk,
    input  logic                 reset_n,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic [1:0]           parity_mode,
    output logic                 data_tx,
    output logic                 active_flag,
    output logic                 done_flag,
    output logic [AW:0]          fifo_level
);

    localparam int             EW         = DATA_BITS + 2;
    localparam logic [AW:0]    FULL_LEVEL = (AW+1)'(FIFO_DEPTH);
    localparam logic [3:0]     LAST_BIT   = 4'(DATA_BITS - 1);
    localparam logic           LAST_STOP  = 1'(STOP_BITS - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    logic [EW-1:0]        mem [FIFO_DEPTH];
    logic [AW-1:0]        wr_ptr;
    logic [AW-1:0]        rd_ptr;
    logic [AW:0]          level;
    logic                 push;
    logic                 pop;
    logic                 frame_end;
    logic [EW-1:0]        head;
    logic [DATA_BITS-1:0] head_data;
    logic [1:0]           head_mode;

    state_t               state;
    logic [DATA_BITS-1:0] shift;
    logic [3:0]           bit_cnt;
    logic                 stop_cnt;
    logic                 par_bit;
    logic                 par_en;

    function automatic logic parity_of(input logic [DATA_BITS-1:0] d, input logic [1:0] m);
        case (m)
            2'b01:   return ^d;
            2'b10:   return ~^d;
            default: return 1'b1;
        endcase
    endfunction

    assign tx_ready   = (level != FULL_LEVEL);
    assign fifo_level = level;
    assign push       = tx_valid && tx_ready;
    assign head       = mem[rd_ptr];
    assign head_data  = head[DATA_BITS-1:0];
    assign head_mode  = head[EW-1 -: 2];
    assign frame_end  = (state == STOP) && (stop_cnt == LAST_STOP);
    // Pop only from registered occupancy, so a freshly pushed word waits one edge.
    assign pop        = (level != '0) && ((state == IDLE) || frame_end);

    always_ff @(posedge baud_clk) begin
        if (push) begin
            mem[wr_ptr] <= {parity_mode, tx_data};
        end
    end

    always_ff @(posedge baud_clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

    always_ff @(posedge baud_clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            data_tx     <= 1'b1;
            active_flag <= 1'b0;
            done_flag   <= 1'b0;
            shift       <= '0;
            bit_cnt     <= '0;
            stop_cnt    <= 1'b0;
            par_bit     <= 1'b0;
            par_en      <= 1'b0;
        end else begin
            done_flag <= frame_end;
            if (pop) begin
                // Load the next word from IDLE or straight out of the last stop bit.
                state       <= START;
                data_tx     <= 1'b0;
                active_flag <= 1'b1;
                shift       <= head_data;
                par_bit     <= parity_of(head_data, head_mode);
                par_en      <= (head_mode != 2'b00);
                bit_cnt     <= '0;
                stop_cnt    <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        data_tx     <= 1'b1;
                        active_flag <= 1'b0;
                    end
                    START: begin
                        state   <= DATA;
                        data_tx <= shift[0];
                        shift   <= shift >> 1;
                        bit_cnt <= '0;
                    end
                    DATA: begin
                        if (bit_cnt == LAST_BIT) begin
                            if (par_en) begin
                                state   <= PARITY;
                                data_tx <= par_bit;
                            end else begin
                                state    <= STOP;
                                data_tx  <= 1'b1;
                                stop_cnt <= 1'b0;
                            end
                        end else begin
                            data_tx <= shift[0];
                            shift   <= shift >> 1;
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end
                    PARITY: begin
                        state    <= STOP;
                        data_tx  <= 1'b1;
                        stop_cnt <= 1'b0;
                    end
                    STOP: begin
                        if (stop_cnt == LAST_STOP) begin
                            state       <= IDLE;
                            data_tx     <= 1'b1;
                            active_flag <= 1'b0;
                        end else begin
                            stop_cnt <= stop_cnt + 1'b1;
                        end
                    end
                    default: begin
                        state       <= IDLE;
                        data_tx     <= 1'b1;
                        active_flag <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_frame.sv
// Bench for uart_tx_frame: an 8N1/4-deep instance and a 7-bit/2-stop instance checked cycle by cycle
// against a frame-level reference model (queued words, frame bit lists, start = max(push+1, prev end)).
module tb_uart_tx_frame;

    logic baud_clk = 1'b0;
    always #5 baud_clk = ~baud_clk;

    logic       reset_n;
    logic       valid_a, valid_b;
    logic       ready_a, ready_b;
    logic [7:0] data_a;
    logic [6:0] data_b;
    logic [1:0] mode_a, mode_b;
    logic       tx_a, tx_b, act_a, act_b, done_a, done_b;
    logic [2:0] lvl_a, lvl_b;

    uart_tx_frame #(.DATA_BITS(8), .STOP_BITS(1), .FIFO_DEPTH(4)) dut_a (
        .baud_clk(baud_clk), .reset_n(reset_n), .tx_valid(valid_a), .tx_ready(ready_a),
        .tx_data(data_a), .parity_mode(mode_a), .data_tx(tx_a), .active_flag(act_a),
        .done_flag(done_a), .fifo_level(lvl_a));

    uart_tx_frame #(.DATA_BITS(7), .STOP_BITS(2), .FIFO_DEPTH(4)) dut_b (
        .baud_clk(baud_clk), .reset_n(reset_n), .tx_valid(valid_b), .tx_ready(ready_b),
        .tx_data(data_b), .parity_mode(mode_b), .data_tx(tx_b), .active_flag(act_b),
        .done_flag(done_b), .fifo_level(lvl_b));

    int         checks = 0;
    int         errors = 0;
    bit         sel;
    int         cyc;
    int         next_free;
    int         fs;
    bit         live;
    int         qd[$];
    logic [1:0] qm[$];
    bit         fbits[$];
    int         done_seen;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Expected bit sequence of one frame, straight from the frame format rules.
    function automatic void make_frame(input int d, input logic [1:0] m);
        int nb;
        int ns;
        int ones;
        nb = sel ? 7 : 8;
        ns = sel ? 2 : 1;
        ones = 0;
        fbits.delete();
        fbits.push_back(1'b0);
        for (int i = 0; i < nb; i++) begin
            fbits.push_back(d[i]);
            ones += int'(d[i]);
        end
        case (m)
            2'b01: fbits.push_back(bit'(ones % 2));
            2'b10: fbits.push_back(bit'(1 - ones % 2));
            2'b11: fbits.push_back(1'b1);
            default: ;
        endcase
        for (int i = 0; i < ns; i++) fbits.push_back(1'b1);
    endfunction

    task automatic model_reset();
        qd.delete();
        qm.delete();
        fbits.delete();
        cyc       = 0;
        next_free = 0;
        fs        = -1000;
        live      = 1'b0;
    endtask

    task automatic step(input bit v, input int d, input logic [1:0] m, output bit acc);
        int   lvl;
        bit   rdy;
        bit   exp_done;
        logic exp_tx;
        logic exp_act;
        valid_a = v && !sel;
        valid_b = v && sel;
        data_a  = d[7:0];
        data_b  = d[6:0];
        mode_a  = m;
        mode_b  = m;
        lvl = qd.size();
        rdy = (lvl != 4);
        chk("tx_ready", 32'(sel ? ready_b : ready_a), 32'(rdy));
        acc = v && rdy;
        @(posedge baud_clk);
        cyc++;
        exp_done = 1'b0;
        if (live && cyc == next_free) begin
            exp_done = 1'b1;
            live     = 1'b0;
        end
        if (lvl > 0 && cyc >= next_free) begin
            make_frame(qd.pop_front(), qm.pop_front());
            fs        = cyc;
            next_free = cyc + fbits.size();
            live      = 1'b1;
        end
        if (acc) begin
            qd.push_back(d);
            qm.push_back(m);
        end
        #1;
        if (cyc >= fs && cyc < next_free) begin
            exp_tx  = fbits[cyc - fs];
            exp_act = 1'b1;
        end else begin
            exp_tx  = 1'b1;
            exp_act = 1'b0;
        end
        chk("data_tx", 32'(sel ? tx_b : tx_a), 32'(exp_tx));
        chk("active_flag", 32'(sel ? act_b : act_a), 32'(exp_act));
        chk("done_flag", 32'(sel ? done_b : done_a), 32'(exp_done));
        chk("fifo_level", 32'(sel ? lvl_b : lvl_a), 32'(qd.size()));
        if (sel ? done_b : done_a) done_seen++;
    endtask

    task automatic send(input int d, input logic [1:0] m);
        bit acc;
        int n;
        n = 0;
        do begin
            step(1'b1, d, m, acc);
            n++;
        end while (!acc && n < 50);
        chk("push_accepted", 32'(acc), 32'd1);
    endtask

    task automatic idle(input int n);
        bit acc;
        for (int i = 0; i < n; i++) step(1'b0, int'($urandom), 2'($urandom), acc);
    endtask

    task automatic check_reset_state();
        chk("rst_data_tx", 32'(sel ? tx_b : tx_a), 32'd1);
        chk("rst_active", 32'(sel ? act_b : act_a), 32'd0);
        chk("rst_done", 32'(sel ? done_b : done_a), 32'd0);
        chk("rst_level", 32'(sel ? lvl_b : lvl_a), 32'd0);
        chk("rst_ready", 32'(sel ? ready_b : ready_a), 32'd1);
    endtask

    task automatic apply_reset();
        valid_a = 1'b0;
        valid_b = 1'b0;
        reset_n = 1'b0;
        repeat (2) @(posedge baud_clk);
        #1;
        check_reset_state();
        reset_n = 1'b1;
        model_reset();
    endtask

    initial begin
        int n;
        sel     = 1'b0;
        valid_a = 1'b0;
        valid_b = 1'b0;
        data_a  = '0;
        data_b  = '0;
        mode_a  = 2'b00;
        mode_b  = 2'b00;
        done_seen = 0;
        apply_reset();

        // Single frames: even, odd and no parity.
        send(32'h55, 2'b01);
        idle(14);
        send(32'h55, 2'b10);
        idle(14);
        send(32'h55, 2'b00);
        idle(13);

        // Six words back-to-back through a 4-deep FIFO.
        done_seen = 0;
        for (int i = 0; i < 6; i++) send(32'hA1 + i, 2'b01);
        idle(72);
        chk("done_pulses_6", 32'(done_seen), 32'd6);

        // parity_mode changes after the push must not affect the queued frame.
        send(32'h0F, 2'b01);
        for (int i = 0; i < 4; i++) begin
            bit acc;
            step(1'b0, 32'h0F, 2'b10, acc);
        end
        send(32'h0F, 2'b10);
        idle(26);

        // Randomized words, modes and gaps.
        for (int i = 0; i < 30; i++) begin
            send(int'($urandom), 2'($urandom));
            idle(int'($urandom_range(0, 12)));
        end
        idle(60);

        // Reset during data bit 3 with two words still queued.
        send(32'h96, 2'b01);
        send(32'h5A, 2'b10);
        send(32'hC3, 2'b11);
        n = 0;
        while (cyc < fs + 4 && n < 20) begin
            idle(1);
            n++;
        end
        chk("queued_before_reset", 32'(lvl_a), 32'd2);
        #3;
        reset_n = 1'b0;
        #1;
        check_reset_state();
        apply_reset();
        send(32'h3C, 2'b01);
        idle(14);

        // 7 data bits, 2 stop bits instance.
        sel = 1'b1;
        apply_reset();
        done_seen = 0;
        send(32'h00, 2'b11);
        idle(16);
        chk("done_pulses_b", 32'(done_seen), 32'd1);
        for (int i = 0; i < 15; i++) begin
            send(int'($urandom), 2'($urandom));
            idle(int'($urandom_range(0, 14)));
        end
        idle(60);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
